// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch queue.
//   RESET_PC_DEFAULT - default PC loaded on reset
//   PC_STEP_DEFAULT  - byte increment per sequential fetch
//   ACCESS_WORD      - access_size encoding for a word read
//   RW_READ          - rw encoding for a read
//   fetch_entry_t    - FIFO entry {pc, inst} for the default 32-bit build
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8002_0000;
    localparam int          PC_STEP_DEFAULT  = 4;
    localparam logic [1:0]  ACCESS_WORD      = 2'b00;
    localparam logic        RW_READ          = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO holding fetched {pc, inst} entries.
// Ports:
//   clock_i  - clock, all updates on posedge
//   reset_i  - synchronous active-high reset, empties the FIFO
//   push_i   - write entry_i at the tail
//   entry_i  - entry to write
//   pop_i    - drop the head entry
//   flush_i  - empty the FIFO; overrides push and pop in the same cycle
//   head_o   - current head entry (valid when count_o != 0)
//   count_o  - occupancy, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  entry_t                 entry_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    // Guard against pushing a full FIFO or popping an empty one.
    assign push_ok = push_i && (count_q != CNT_W'(DEPTH)) && !flush_i;
    assign pop_ok  = pop_i && (count_q != '0) && !flush_i;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count decide which entries are meaningful.
    always_ff @(posedge clock_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : fetch_fifo

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage. Holds the fetch PC, issues word reads
// over a ready/valid handshake with variable latency, buffers returned
// instructions with their PCs, and flushes on redirect.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds fetch_fault, which is set
// by a misaligned redirect and blocks issue until an aligned redirect or reset.
// Ports:
//   clock, reset              - clock and synchronous active-high reset
//   stall                     - decode not accepting; head entry held
//   redirect_valid/_pc        - load new PC and flush buffered/in-flight fetches
//   i_mem_enable, i_mem_ready - request handshake; address = current PC
//   rw, access_size           - constant read / word
//   i_mem_rdata_valid/_rdata  - in-order responses
//   inst_valid/inst_out/pc_out- FIFO head
//   fetch_fault               - (optional) misaligned redirect seen
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                PC_STEP  = PC_STEP_DEFAULT,
    parameter int                DEPTH    = 4,
    parameter int                DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              i_mem_enable,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] address,
    output logic              rw,
    output logic [1:0]        access_size,
    input  logic              i_mem_rdata_valid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic              fetch_fault
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  live_q, live_d;
    logic [CNT_W-1:0]  squash_q, squash_d;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W:0]    outstanding;
    logic              credit_ok;
    logic              fault_block;
    logic              accept;
    logic              resp_keep;
    logic              pop;
    entry_t            push_entry;
    entry_t            head;

    // Every FIFO slot is reserved at issue time: buffered entries, live
    // requests and requests that will be dropped all count against DEPTH,
    // so a response can always be pushed. Extra bit avoids wrap in the sum.
    assign outstanding = {1'b0, occupancy} + {1'b0, live_q} + {1'b0, squash_q};
    assign credit_ok   = outstanding < (CNT_W+1)'(DEPTH);

    assign i_mem_enable = !reset && !redirect_valid && credit_ok && !fault_block;
    assign accept       = i_mem_enable && i_mem_ready;

    // A response belongs to the current stream only when nothing is left to
    // squash; anything arriving in a redirect cycle is stale.
    assign resp_keep = i_mem_rdata_valid && (squash_q == '0) && !redirect_valid;
    assign pop       = inst_valid && !stall;

    assign push_entry.pc   = resp_pc_q;
    assign push_entry.inst = i_mem_rdata;

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        live_d    = live_q;
        squash_d  = squash_q;
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            resp_pc_d = redirect_pc;
            live_d    = '0;
            // Everything still outstanding becomes stale; a response landing
            // this cycle retires one of them immediately.
            squash_d  = squash_q + live_q - CNT_W'(i_mem_rdata_valid);
        end else begin
            if (accept) pc_d = pc_q + ADDR_W'(PC_STEP);
            if (i_mem_rdata_valid && (squash_q != '0)) squash_d = squash_q - CNT_W'(1);
            if (resp_keep) resp_pc_d = resp_pc_q + ADDR_W'(PC_STEP);
            live_d = live_q + CNT_W'(accept) - CNT_W'(resp_keep);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            live_q    <= '0;
            squash_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            live_q    <= live_d;
            squash_q  <= squash_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    // Each redirect re-evaluates alignment: misaligned sets, aligned clears.
    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) fault_d = (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clock) begin
        if (reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end

    assign fetch_fault = fault_q;
    assign fault_block = fault_q;
`else
    assign fault_block = 1'b0;
`endif

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock_i (clock),
        .reset_i (reset),
        .push_i  (resp_keep),
        .entry_i (push_entry),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .head_o  (head),
        .count_o (occupancy)
    );

    assign address     = pc_q;
    assign rw          = RW_READ;
    assign access_size = ACCESS_WORD;
    assign inst_valid  = (occupancy != '0);
    assign inst_out    = head.inst;
    assign pc_out      = head.pc;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with an in-order
// variable-latency memory responder and a PC/instruction scoreboard.
module tb_fetch_queue;

    localparam logic [31:0] RST_PC = 32'h8002_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        i_mem_enable;
    logic        i_mem_ready = 1'b1;
    logic [31:0] address;
    logic        rw;
    logic [1:0]  access_size;
    logic        i_mem_rdata_valid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    int          pop_cnt = 0;
    int          mem_lat = 1;
    int          cyc     = 0;
    int          acc_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t pend_q [$];

    fetch_queue dut (
        .clock             (clock),
        .reset             (reset),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .i_mem_enable      (i_mem_enable),
        .i_mem_ready       (i_mem_ready),
        .address           (address),
        .rw                (rw),
        .access_size       (access_size),
        .i_mem_rdata_valid (i_mem_rdata_valid),
        .i_mem_rdata       (i_mem_rdata),
        .inst_valid        (inst_valid),
        .inst_out          (inst_out),
        .pc_out            (pc_out)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault       (fetch_fault)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // In-order memory: a request accepted at edge k is presented during the
    // cycle after edge k+mem_lat-1, returning address ^ FFFF_FFFF.
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            pend_q.delete();
            i_mem_rdata_valid <= 1'b0;
            i_mem_rdata       <= '0;
        end else begin
            if (i_mem_enable && i_mem_ready) begin
                pend_q.push_back('{address, cyc + mem_lat - 1});
                acc_cnt++;
            end
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                i_mem_rdata_valid <= 1'b1;
                i_mem_rdata       <= pend_q[0].addr ^ 32'hFFFF_FFFF;
                void'(pend_q.pop_front());
            end else begin
                i_mem_rdata_valid <= 1'b0;
                i_mem_rdata       <= '0;
            end
        end
    end

    // Scoreboard: every instruction that will be popped at the next edge
    // must be the next expected PC with its memory image.
    always @(negedge clock) begin
        if (!reset && !redirect_valid && inst_valid && !stall) begin
            mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEE0;
            check("out_pc", 64'(pc_out), 64'(mon_exp));
            check("out_inst", 64'(inst_out), 64'(mon_exp ^ 32'hFFFF_FFFF));
            pop_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_stream(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        start_stream(RST_PC);
        step();
        step();
        @(negedge clock);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_enable", 64'(i_mem_enable), 64'd0);
        check("rst_address", 64'(address), 64'(RST_PC));
        check("rst_rw", 64'(rw), 64'd1);
        check("rst_access_size", 64'(access_size), 64'd0);
        step();
        acc_cnt = 0;
        pop_cnt = 0;
        reset   = 1'b0;
    endtask

    logic [31:0] exp_addr;
    logic        acc;

    initial begin
        // Basic stream, 1-cycle memory.
        mem_lat = 1;
        apply_reset();
        @(negedge clock);
        check("t1_first_enable", 64'(i_mem_enable), 64'd1);
        check("t1_first_addr", 64'(address), 64'h8002_0000);
        check("t1_valid_n0", 64'(inst_valid), 64'd0);
        step();
        @(negedge clock);
        check("t1_valid_n1", 64'(inst_valid), 64'd0);
        check("t1_second_addr", 64'(address), 64'h8002_0004);
        step();
        @(negedge clock);
        check("t1_valid_n2", 64'(inst_valid), 64'd1);
        check("t1_first_pc", 64'(pc_out), 64'h8002_0000);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clock);
            check("t1_stream_valid", 64'(inst_valid), 64'd1);
        end
        step();
        check("t1_throughput", 64'(pop_cnt), 64'd7);

        // Stall fills the FIFO and exhausts credit.
        stall = 1'b1;
        apply_reset();
        repeat (10) step();
        @(negedge clock);
        check("t2_accepts", 64'(acc_cnt), 64'd4);
        check("t2_enable_off", 64'(i_mem_enable), 64'd0);
        check("t2_head_valid", 64'(inst_valid), 64'd1);
        check("t2_head_pc", 64'(pc_out), 64'h8002_0000);
        step();
        stall = 1'b0;
        repeat (4) step();
        check("t2_drain_cnt", 64'(pop_cnt), 64'd4);
        repeat (4) step();

        // Redirect with three requests in flight, 3-cycle memory.
        mem_lat = 3;
        apply_reset();
        for (int n = 0; n < 20 && (pend_q.size() + int'(i_mem_rdata_valid)) != 3; n++) step();
        check("t3_inflight", 64'(pend_q.size() + int'(i_mem_rdata_valid)), 64'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8003_0000;
        start_stream(32'h8003_0000);
        @(negedge clock);
        check("t3_no_issue", 64'(i_mem_enable), 64'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clock);
        check("t3_flushed", 64'(inst_valid), 64'd0);
        for (int n = 0; n < 30 && !inst_valid; n++) step();
        @(negedge clock);
        check("t3_valid_seen", 64'(inst_valid), 64'd1);
        check("t3_new_pc", 64'(pc_out), 64'h8003_0000);

        // Redirect coinciding with a response and a pop.
        mem_lat = 1;
        repeat (6) step();
        for (int n = 0; n < 20 && !(i_mem_rdata_valid && inst_valid); n++) step();
        check("t4_resp_and_pop", 64'(i_mem_rdata_valid && inst_valid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8004_0000;
        start_stream(32'h8004_0000);
        @(negedge clock);
        check("t4_no_issue", 64'(i_mem_enable), 64'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clock);
        check("t4_flushed", 64'(inst_valid), 64'd0);
        check("t4_addr", 64'(address), 64'h8004_0000);
        check("t4_enable", 64'(i_mem_enable), 64'd1);
        for (int n = 0; n < 20 && !inst_valid; n++) step();
        @(negedge clock);
        check("t4_new_pc", 64'(pc_out), 64'h8004_0000);
        check("t4_new_inst", 64'(inst_out), 64'h7FFB_FFFF);

        // Alternating ready: PC advances only on accepted cycles.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8005_0000;
        start_stream(32'h8005_0000);
        step();
        redirect_valid = 1'b0;
        exp_addr = 32'h8005_0000;
        for (int i = 0; i < 16; i++) begin
            i_mem_ready = (i % 2 == 0);
            @(negedge clock);
            check("t5_addr", 64'(address), 64'(exp_addr));
            acc = i_mem_enable && i_mem_ready;
            step();
            if (acc) exp_addr = exp_addr + 32'd4;
        end
        i_mem_ready = 1'b1;
        @(negedge clock);
        check("t5_final_addr", 64'(address), 64'h8005_0020);
        repeat (10) step();

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect blocks issue until an aligned redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8003_0002;
        exp_q.delete();
        step();
        redirect_valid = 1'b0;
        @(negedge clock);
        check("t6_fault_set", 64'(fetch_fault), 64'd1);
        check("t6_enable_off", 64'(i_mem_enable), 64'd0);
        repeat (4) step();
        @(negedge clock);
        check("t6_still_off", 64'(i_mem_enable), 64'd0);
        check("t6_no_inst", 64'(inst_valid), 64'd0);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8003_0000;
        start_stream(32'h8003_0000);
        step();
        redirect_valid = 1'b0;
        @(negedge clock);
        check("t6_fault_clear", 64'(fetch_fault), 64'd0);
        check("t6_enable_on", 64'(i_mem_enable), 64'd1);
        for (int n = 0; n < 20 && !inst_valid; n++) step();
        @(negedge clock);
        check("t6_resume_pc", 64'(pc_out), 64'h8003_0000);
        repeat (4) step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch stage for the MIPS pipeline. Keeps the PC and issues word reads to instruction memory over a ready/valid handshake with variable latency.
- Buffers returned instructions with their PCs in a FIFO, so decode back-pressure does not stall memory traffic.
- Supports PC redirect (branch/jump) with flush of buffered and in-flight fetches.

Parameters:
- ADDR_W, 32, PC/address width
- RESET_PC, 32'h80020000, PC loaded on reset
- PC_STEP, 4, byte increment per sequential fetch
- DEPTH, 4, instruction FIFO entries (power of two, >=2); also the bound on total outstanding requests
- DATA_W, 32, instruction width

Ports:
- clock  in  1  sole clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- stall  in  1  decode not accepting; head entry held
- redirect_valid  in  1  load redirect_pc, flush
- redirect_pc  in  ADDR_W  new fetch PC
- i_mem_enable  out  1  request valid
- i_mem_ready  in  1  memory accepts request this cycle
- address  out  ADDR_W  request address (= pc)
- rw  out  1  constant 1 (read)
- access_size  out  2  constant 2'b00 (word)
- i_mem_rdata_valid  in  1  response valid; responses return in request order
- i_mem_rdata  in  DATA_W  response data
- inst_valid  out  1  FIFO head valid
- inst_out  out  DATA_W  head instruction
- pc_out  out  ADDR_W  head PC

Behaviour:
- Reset (sync, high):
  - pc=RESET_PC; resp_pc=RESET_PC; FIFO empty.
  - live_cnt=0; squash_cnt=0.
  - inst_valid=0; i_mem_enable=0; address=RESET_PC; rw=1; access_size=0.
  - Instruction memory shares this reset; no pre-reset responses arrive afterwards.
- Issue:
  - i_mem_enable = !reset && !redirect_valid && (occupancy + live_cnt + squash_cnt < DEPTH).
  - address = pc (combinational).
  - Accept = i_mem_enable && i_mem_ready. On accept: pc += PC_STEP (mod 2^ADDR_W, wraps silently); live_cnt++.
- Response:
  - If squash_cnt>0: drop the response; squash_cnt--.
  - Else: push {resp_pc, i_mem_rdata} into FIFO; resp_pc += PC_STEP; live_cnt--.
  - A push never overflows, by the credit rule.
- Consume:
  - inst_valid = occupancy>0.
  - Pop when inst_valid && !stall.
  - stall=1: head, inst_out and pc_out hold; fetch continues until credit is exhausted.
- Same-cycle push and pop: occupancy unchanged. Full FIFO with pop: enable may rise the next cycle, not the same cycle.
- Redirect, effective at the next edge:
  - pc=resp_pc=redirect_pc; FIFO emptied (a pop in the same cycle is ignored).
  - squash_cnt = squash_cnt + live_cnt - (1 if a response arrives this cycle).
  - live_cnt=0. Any response in the redirect cycle is dropped.
  - No issue in the redirect cycle. inst_valid=0 the next cycle.
- Latency: with a 1-cycle memory and ready=1, request at cycle N, data returns N+1, inst_valid at N+2. Throughput is 1 instruction/cycle.
- Redirect during reset: reset wins.
- Counters are width clog2(DEPTH)+1.

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined:
  - Extra output fetch_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1, still flushes, and holds i_mem_enable=0 until the next reset or an aligned redirect, which clears fetch_fault.
- Undefined: no port; low bits are used as given.

Decomposition:
- Package fetch_pkg: RESET_PC default, PC_STEP, ACCESS_WORD=2'b00, RW_READ=1'b1, and the FIFO entry struct {pc, inst}.
- One sub-module, fetch_fifo: synchronous DEPTH-entry FIFO with push/pop/flush and occupancy output, same clock/reset.

Test Plan:
- Reset, ready=1, 1-cycle memory returning addr^32'hFFFF_FFFF, stall=0 -> address sequence 80020000, 80020004, …; first inst_valid 2 cycles after reset release with pc_out=80020000; one instruction per cycle thereafter.
- stall=1 held 10 cycles -> exactly 4 accepts (DEPTH=4), then i_mem_enable=0. Head stays at 80020000. Release -> in-order drain 80020000..8002000C.
- 3-cycle memory latency, redirect to 80030000 with 3 requests in flight -> 3 responses dropped; next inst_valid has pc_out=80030000.
- Redirect in the same cycle as a response and a pop -> response dropped, FIFO empty next cycle, no issue that cycle, squash_cnt correct.
- i_mem_ready toggling 1010… -> pc advances only on accepted cycles; no duplicate or skipped PCs at the output.
- With FETCH_ALIGN_CHECK_EN: redirect to 80030002 -> fetch_fault=1, no requests. Aligned redirect to 80030000 -> fault clears, fetch resumes.
